ir_fetch_unit: RTL and testbench
================================

Name: ir_fetch_unit

Overview:
- Instruction fetch front end that produces the `ir` stream consumed by the RV32I decode/control stage.
- Issues in-order word fetches to instruction memory over a valid/ready request channel and accepts in-order responses that cannot be backpressured.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready channel.
- Supports a redirect from execute (branch/jump), which flushes buffered and in-flight instructions.

Parameters:
- IR_WIDTH, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also caps outstanding requests.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  IR_WIDTH  fetch address (word aligned).
- imem_rsp_valid  in  1  response word valid; always accepted, in request order.
- imem_rsp_data  in  IR_WIDTH  fetched instruction word.
- ir_valid  out  1  buffer head valid to decode.
- ir_ready  in  1  decode consumes head.
- ir  out  IR_WIDTH  instruction at buffer head.
- ir_pc  out  IR_WIDTH  PC of instruction at buffer head.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  IR_WIDTH  new fetch PC.

Behaviour:
- Reset (rst high at an edge) sets:
  - pc=RESET_PC; fifo count, outstanding_cnt and drop_cnt all 0.
  - imem_req_valid=0, ir_valid=0, ir=0, ir_pc=0 after the edge.
  - Reset mid-operation abandons all state. Responses arriving after reset belong to the pre-reset epoch and are counted as 0; the memory is reset together with this block.
- Request channel:
  - imem_req_valid = !redirect_valid && (outstanding_cnt + count < FIFO_DEPTH).
  - imem_req_addr = pc.
  - On valid&&ready: pc <= pc+4 (mod 2^IR_WIDTH wrap, no flag) and outstanding_cnt++.
  - imem_req_valid never depends on imem_req_ready.
- Response handling:
  - If drop_cnt != 0: word discarded, drop_cnt--.
  - Otherwise: word pushed with its PC. A PC FIFO parallel to the request stream, or a pc_rsp counter, supplies the PC.
  - outstanding_cnt-- in both cases.
  - The credit rule guarantees the push never overflows.
  - Simultaneous request accept and response: outstanding_cnt is unchanged.
- Decode channel:
  - ir_valid = (count != 0) && !redirect_valid.
  - ir and ir_pc come from the head entry (FIFO read is combinational from registered storage).
  - Pop on ir_valid&&ir_ready.
  - Push and pop in the same cycle leaves count unchanged; this is legal when full or empty.
  - A response pushed at cycle t is visible on ir_valid at t+1; minimum fetch-to-decode latency is request cycle + memory latency + 1.
- Redirect (redirect_valid at cycle t), which has priority over everything:
  - FIFO cleared.
  - pc <= redirect_pc.
  - drop_cnt <= outstanding_cnt - imem_rsp_valid; a response in cycle t is itself discarded.
  - No request is issued and no pop occurs in cycle t.
  - The first request with the new pc appears at t+1.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each cycle.
- Misalignment: redirect_pc[1:0] != 0 is handled by the optional feature below.
- Single FSM with states FETCH and HALT. HALT exists only with the macro; without it the block is always in FETCH.

Optional Feature:
- Macro IR_FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 enters HALT, sets fetch_misaligned=1, flushes as normal and holds imem_req_valid=0. Stale responses are still dropped.
  - A later aligned redirect returns to FETCH and clears the flag the next cycle.
- Undefined:
  - No port.
  - redirect_pc[1:0] is forced to 2'b00.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr as data -> requests at 0x0, 0x4, 0x8, 0xC; stops at 4 outstanding+buffered while ir_ready=0; ir=0x0, ir_pc=0x0 first.
- ir_ready=1 continuous, zero-wait memory -> one instruction per cycle in order after fill; count never exceeds FIFO_DEPTH.
- Redirect to 0x100 with 3 outstanding and an in-flight response that same cycle -> all 3 discarded, next ir_pc=0x100, no old PC ever seen by decode.
- imem_req_ready toggling 1/0, random ir_ready -> in-order ir_pc sequence 0x0, 0x4, ... with no gaps or duplicates.
- pc at 0xFFFF_FFFC -> next request addr 0x0000_0000.
- With IR_FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> fetch_misaligned=1, no requests; redirect to 0x200 -> flag 0, fetch resumes at 0x200.

Source files
------------

// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit
//   Instruction fetch front end for the RV32I decode/control stage. Issues
//   in-order word fetches to instruction memory, buffers the returned words
//   together with their PCs in a small FIFO, and presents the head entry to
//   decode. A redirect from execute flushes the buffer. It also marks every
//   in-flight response so that the response is dropped when it returns.
//
// Optional build macro: IR_FETCH_ALIGN_CHECK_EN
//   When defined, a redirect to a PC that is not word aligned parks the unit in
//   HALT and raises fetch_misaligned. A later aligned redirect resumes fetch.
//   When undefined, redirect_pc[1:0] is ignored and treated as 2'b00.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   imem_req_valid    fetch request valid (never depends on imem_req_ready)
//   imem_req_ready    memory accepts the request
//   imem_req_addr     word-aligned fetch address
//   imem_rsp_valid    response word valid, in request order, not stallable
//   imem_rsp_data     fetched instruction word
//   ir_valid          buffer head valid towards decode
//   ir_ready          decode consumes the head entry
//   ir, ir_pc         instruction word and PC at the buffer head
//   redirect_valid    flush and restart fetch at redirect_pc
//   redirect_pc       new fetch PC
//   fetch_misaligned  (macro only) set while halted on a misaligned redirect

module ir_fetch_unit #(
    parameter int                     IR_WIDTH   = 32,
    parameter logic [IR_WIDTH-1:0]    RESET_PC   = '0,
    parameter int                     FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [IR_WIDTH-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [IR_WIDTH-1:0] imem_rsp_data,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [IR_WIDTH-1:0] ir,
    output logic [IR_WIDTH-1:0] ir_pc,
    input  logic                redirect_valid,
    input  logic [IR_WIDTH-1:0] redirect_pc
`ifdef IR_FETCH_ALIGN_CHECK_EN
    ,
    output logic                fetch_misaligned
`endif
);

    localparam int                  PTR_W        = $clog2(FIFO_DEPTH);
    localparam int                  CNT_W        = PTR_W + 1;
    localparam logic [CNT_W:0]      DEPTH_CREDIT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [IR_WIDTH-1:0] WORD_STEP    = IR_WIDTH'(4);

`ifdef IR_FETCH_ALIGN_CHECK_EN
    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;
`else
    typedef enum logic {FETCH = 1'b0} state_t;
`endif

    state_t state;
    state_t state_next;

    logic [IR_WIDTH-1:0] pc;
    // PC of the next response that will be pushed; advances only on pushes so
    // dropped (stale) responses never consume a PC of the new stream.
    logic [IR_WIDTH-1:0] pc_rsp;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    outstanding_cnt;
    logic [CNT_W-1:0]    drop_cnt;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;

    logic [IR_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [IR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

    logic [IR_WIDTH-1:0] redirect_target;
    logic                redirect_misaligned;
    logic                credit_ok;
    logic                req_fire;
    logic                push;
    logic                pop;
    logic                rsp_drop;
    logic                not_empty;

    assign redirect_target = {redirect_pc[IR_WIDTH-1:2], 2'b00};

`ifdef IR_FETCH_ALIGN_CHECK_EN
    assign redirect_misaligned = |redirect_pc[1:0];
    assign fetch_misaligned    = (state == HALT);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_misaligned  = 1'b0;
`endif

    // Requests in flight plus buffered words may never exceed the buffer size,
    // so every response that is kept always finds a free slot.
    assign credit_ok = ({1'b0, outstanding_cnt} + {1'b0, count}) < DEPTH_CREDIT;
    assign not_empty = (count != '0);

    assign imem_req_valid = !rst && !redirect_valid && (state == FETCH) && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign push     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    assign ir_valid = not_empty && !redirect_valid;
    assign pop      = ir_valid && ir_ready;

    // Head is read combinationally; an empty buffer shows zeros so the
    // outputs are defined right after reset without resetting the storage.
    assign ir    = not_empty ? fifo_data[rd_ptr] : '0;
    assign ir_pc = not_empty ? fifo_pc[rd_ptr]   : '0;

    always_comb begin
        state_next = state;
`ifdef IR_FETCH_ALIGN_CHECK_EN
        if (redirect_valid) begin
            state_next = redirect_misaligned ? HALT : FETCH;
        end
`else
        state_next = FETCH;
        if (redirect_misaligned) begin
            state_next = FETCH;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            pc_rsp          <= RESET_PC;
            count           <= '0;
            outstanding_cnt <= '0;
            drop_cnt        <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                // A response arriving in the redirect cycle is discarded here,
                // so only the remaining in-flight requests need dropping later.
                pc              <= redirect_target;
                pc_rsp          <= redirect_target;
                count           <= '0;
                rd_ptr          <= '0;
                wr_ptr          <= '0;
                outstanding_cnt <= outstanding_cnt - CNT_W'(imem_rsp_valid);
                drop_cnt        <= outstanding_cnt - CNT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + WORD_STEP;
                end
                if (push) begin
                    pc_rsp <= pc_rsp + WORD_STEP;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                outstanding_cnt <= outstanding_cnt + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
                count           <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= pc_rsp;
        end
    end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb_ir_fetch_unit
//   Directed bench for ir_fetch_unit. A behavioural instruction memory with a
//   selectable fixed latency returns the request address as the data word. A
//   negedge monitor tracks the expected request address and the expected
//   decode PC stream; the main sequence drives the directed scenarios.

module tb_ir_fetch_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IR_FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int          checks = 0;
    int          errors = 0;
    int          reqs   = 0;
    int          pops   = 0;
    int          p0;
    int          mem_lat = 1;
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_pop = 32'h0;

    logic        pipe_v [4];
    logic [31:0] pipe_d [4];

    ir_fetch_unit #(
        .IR_WIDTH   (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IR_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency memory: data word equals the request address.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= req_valid && req_ready;
            pipe_d[0] <= req_addr;
            for (int i = 1; i < 4; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end
    assign rsp_valid = pipe_v[mem_lat-1];
    assign rsp_data  = pipe_d[mem_lat-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor: request order, decode order, and redirect-cycle quiet.
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_valid) begin
                check("req_in_redirect", {31'b0, req_valid}, 32'h0);
                check("ir_in_redirect", {31'b0, ir_valid}, 32'h0);
            end
            if (req_valid && req_ready) begin
                check("req_addr", req_addr, exp_req);
                exp_req = exp_req + 32'h4;
                reqs++;
            end
            if (ir_valid && ir_ready) begin
                check("ir_pc", ir_pc, exp_pop);
                check("ir_word", ir, exp_pop);
                exp_pop = exp_pop + 32'h4;
                pops++;
            end
        end
    end

    task automatic do_reset(input int lat);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ir_ready       = 1'b0;
        req_ready      = 1'b0;
        mem_lat        = lat;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", {31'b0, req_valid}, 32'h0);
        check("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_pc", ir_pc, 32'h0);
`ifdef IR_FETCH_ALIGN_CHECK_EN
        check("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);
`endif
        tick();
        exp_req = 32'h0;
        exp_pop = 32'h0;
        reqs    = 0;
        pops    = 0;
        rst     = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        req_ready      = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Fill with decode stalled: four requests, then credit exhausted.
        do_reset(1);
        req_ready = 1'b1;
        tick();
        @(negedge clk);
        check("fill_c1_ir_valid", {31'b0, ir_valid}, 32'h0);
        tick();
        @(negedge clk);
        check("fill_c2_ir_valid", {31'b0, ir_valid}, 32'h1);
        repeat (6) tick();
        @(negedge clk);
        check("stall_req_valid", {31'b0, req_valid}, 32'h0);
        check("stall_reqs", reqs, 32'd4);
        check("stall_ir_valid", {31'b0, ir_valid}, 32'h1);
        check("stall_ir", ir, 32'h0);
        check("stall_ir_pc", ir_pc, 32'h0);
        check("stall_pops", pops, 32'd0);
        tick();

        // Continuous decode: one instruction per cycle once flowing.
        ir_ready = 1'b1;
        repeat (20) tick();
        p0 = pops;
        repeat (16) tick();
        check("stream_rate", pops - p0, 32'd16);

        // Redirect with 3 outstanding and a response returning that cycle.
        do_reset(3);
        req_ready = 1'b1;
        ir_ready  = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        exp_req        = 32'h0000_0100;
        exp_pop        = 32'h0000_0100;
        p0             = pops;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        check("redirect_resumed", {31'b0, (pops - p0) >= 8}, 32'h1);
        check("redirect_no_old", p0, 32'd0);

        // Request ready toggling with random decode readiness.
        do_reset(2);
        for (int i = 0; i < 60; i++) begin
            req_ready = i[0];
            ir_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        check("toggle_progress", {31'b0, pops >= 10}, 32'h1);

        // Address wrap at the top of the address space.
        do_reset(1);
        req_ready      = 1'b1;
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        exp_req        = 32'hFFFF_FFFC;
        exp_pop        = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_req_valid", {31'b0, req_valid}, 32'h1);
        check("wrap_addr_top", req_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_addr_zero", req_addr, 32'h0000_0000);
        repeat (8) tick();
        check("wrap_pops", {31'b0, pops >= 4}, 32'h1);

`ifdef IR_FETCH_ALIGN_CHECK_EN
        // Misaligned redirect halts; an aligned redirect resumes.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        exp_req        = 32'h0000_0200;
        exp_pop        = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("halt_flag", {31'b0, fetch_misaligned}, 32'h1);
        check("halt_req_valid", {31'b0, req_valid}, 32'h0);
        repeat (4) tick();
        @(negedge clk);
        check("halt_hold_flag", {31'b0, fetch_misaligned}, 32'h1);
        check("halt_hold_req", {31'b0, req_valid}, 32'h0);
        check("halt_hold_ir", {31'b0, ir_valid}, 32'h0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume_flag", {31'b0, fetch_misaligned}, 32'h0);
        check("resume_req_valid", {31'b0, req_valid}, 32'h1);
        check("resume_addr", req_addr, 32'h0000_0200);
        p0 = pops;
        repeat (8) tick();
        check("resume_pops", {31'b0, (pops - p0) >= 4}, 32'h1);
`else
        // Low PC bits of a redirect are ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0106;
        exp_req        = 32'h0000_0104;
        exp_pop        = 32'h0000_0104;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("align_req_valid", {31'b0, req_valid}, 32'h1);
        check("align_addr", req_addr, 32'h0000_0104);
        p0 = pops;
        repeat (8) tick();
        check("align_pops", {31'b0, (pops - p0) >= 4}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
